tetris_game_ctrl: RTL and testbench
===================================

Name: tetris_game_ctrl

Overview:
- Parametrised game-flow controller for the Tetris core, placed between the keyboard keycode path, the piece picker, and the block/collision datapath.
- Sequences start, drop, fall, hold, bottom and pause, as the previous controller did.
- Adds four things the previous controller lacked:
  - key edge detection,
  - a real hold/swap slot,
  - an internal gravity timer that speeds up with level,
  - line/level accounting with top-out game-over.

Parameters:
- PIECE_W, 16, width of the piece occupancy bitmap (blockstate).
- SPRITE_W, 6, width of the sprite index.
- KEY_START, 8'h2C, start/restart keycode (space).
- KEY_PAUSE, 8'h13, pause toggle keycode (P).
- KEY_HOLD, 8'h2B, hold keycode (tab).
- KEY_QUIT, 8'h29, abort-to-idle keycode (esc).
- GRAV_W, 24, width of the gravity counter.
- GRAV_INIT, 24'd5_000_000, gravity period at level 0, in cycles.
- GRAV_STEP, 24'd400_000, period reduction per level.
- GRAV_MIN, 24'd500_000, floor on the gravity period.
- LINES_PER_LEVEL, 10, cleared lines per level increment.
- LEVEL_W, 4, level width; the level saturates at 2^LEVEL_W-1.
- LINES_W, 12, width of the total-lines counter; saturating.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- keycode  in  8  current keyboard code; 8'h00 = no key.
- hitbottom  in  1  active piece has landed (from collision logic).
- topout  in  1  new piece overlaps the stack; valid in DROP.
- lines_cleared  in  3  lines removed by the landing; valid while hitbottom=1 (0..4).
- pick_blockstate  in  PIECE_W  picker output, combinational, valid when pick_req=1.
- pick_sprite  in  SPRITE_W  picker sprite index.
- pick_req  out  1  one-cycle request; the picker advances on this cycle.
- blockstate_new  out  PIECE_W  active piece bitmap.
- spriteindex  out  SPRITE_W  active piece sprite.
- blockstate_hold  out  PIECE_W  held piece bitmap.
- spriteindex_hold  out  SPRITE_W  held piece sprite.
- hold_valid  out  1  hold slot occupied.
- resetBlocks  out  1  one-cycle pulse; datapath respawns the active piece at the top.
- drop_tick  out  1  one-cycle gravity pulse; move the piece down one row.
- Pause  out  1  freeze datapath.
- game_over  out  1  top-out latched.
- level  out  LEVEL_W  current level.
- lines_total  out  LINES_W  total cleared lines.

Behaviour:
- Reset values: every register and output is 0 and the state is WAIT.
  - Exception: can_hold=1.
  - Pause is Moore-driven, so it reads 1 in WAIT after reset.
- Key press definition:
  - press(K) = (keycode==K) && (key_q!=K), where key_q is keycode registered every cycle (reset 8'h00).
  - A held key therefore acts exactly once.
- States: WAIT, DROP, FALLING, HOLD, BOTTOM, PAUSED, OVER.
- WAIT:
  - Outputs Pause=1 and pick_req=1 (keeps the picker randomising).
  - On press(KEY_START): clear level, lines_total, hold slot and hold_valid; set can_hold=1; go to DROP.
- DROP (exactly 1 cycle):
  - Outputs pick_req=1 and resetBlocks=1.
  - Loads blockstate_new/spriteindex from pick_*.
  - If topout=1: go to OVER; otherwise go to FALLING.
  - Clears the gravity counter.
- FALLING: transitions use this priority, highest first:
  1. press(KEY_QUIT) -> WAIT.
  2. hitbottom -> BOTTOM.
  3. press(KEY_HOLD) && can_hold -> HOLD.
  4. press(KEY_PAUSE) -> PAUSED.
  5. Otherwise stay in FALLING.
- Gravity counter (FALLING only):
  - Increments each FALLING cycle.
  - When count == period-1: drop_tick=1 for that cycle and the count goes to 0.
  - period = max(GRAV_INIT - level*GRAV_STEP, GRAV_MIN). Compute at GRAV_W+LEVEL_W bits; an underflow clamps to GRAV_MIN.
  - The counter holds its value in PAUSED. It is cleared in DROP and HOLD.
  - drop_tick is never asserted outside FALLING.
- HOLD (1 cycle), with can_hold forced to 0:
  - If hold_valid=0: hold slot takes the active piece; active piece takes pick_*; pick_req=1; hold_valid goes to 1.
  - If hold_valid=1: active piece and hold slot swap; pick_req=0.
  - In both cases resetBlocks=1, then go to FALLING.
- BOTTOM (1 cycle):
  - lines_total += lines_cleared, saturating.
  - Add 1 to level for each LINES_PER_LEVEL boundary crossed by lines_total, saturating.
  - Set can_hold=1, then go to DROP.
- PAUSED:
  - Outputs Pause=1.
  - press(KEY_PAUSE) -> FALLING.
  - press(KEY_QUIT) -> WAIT; quit wins if both are seen.
  - hitbottom is ignored.
- OVER:
  - Outputs Pause=1 and game_over=1.
  - press(KEY_START) -> WAIT; game_over clears on leaving OVER.
- Simultaneous events:
  - hitbottom together with a hold press: hitbottom wins and the hold is lost.
  - Async reset mid-game returns everything to the reset values within the same cycle.
- All state outputs are registered. pick_req, resetBlocks and drop_tick are decoded from the state register, so they carry no combinational path from keycode.

Test Plan:
Benches use GRAV_INIT=8, GRAV_STEP=2, GRAV_MIN=2, LINES_PER_LEVEL=4.
- Reset, then keycode=8'h2C held for 20 cycles -> exactly one DROP cycle (resetBlocks=1, pick_req=1, blockstate_new=pick_blockstate), then FALLING; holding the key causes no re-trigger.
- FALLING for 24 cycles at level 0 -> drop_tick on cycles 8, 16, 24 of FALLING only. Pause press at cycle 12, release, press again 30 cycles later -> no ticks while paused; next tick after 4 more FALLING cycles.
- First hold with pick 16'h0F00/sprite 3 while active is 16'h4460 -> hold=16'h4460, active=16'h0F00, hold_valid=1. Second hold press before bottom -> ignored. After BOTTOM/DROP, hold press -> swap, pick_req=0.
- hitbottom with lines_cleared=3, then 3 again -> lines_total=6, level=1, gravity period 6. Drive to level 7 -> period clamps to 2.
- topout=1 in DROP -> OVER with game_over=1, Pause=1. Then 8'h2C -> WAIT; next 8'h2C clears lines_total and level to 0.
- Reset_n driven low asynchronously mid-FALLING -> state WAIT, hold_valid=0, level=0 immediately, no drop_tick.

Source files
------------

// File: rtl/tetris_game_ctrl_if.sv
// Signal bundle between the Tetris game-flow controller and its keyboard, picker
// and block/collision datapath neighbours.
interface tetris_game_ctrl_if #(
    parameter int PIECE_W  = 16,
    parameter int SPRITE_W = 6,
    parameter int LEVEL_W  = 4,
    parameter int LINES_W  = 12
);
    // Picker handshake: pick_blockstate/pick_sprite are valid in every cycle with
    // pick_req=1, are consumed in that same cycle, and the picker advances on it.
    logic [7:0]          keycode;
    logic                hitbottom;
    logic                topout;
    logic [2:0]          lines_cleared;
    logic [PIECE_W-1:0]  pick_blockstate;
    logic [SPRITE_W-1:0] pick_sprite;

    logic                pick_req;
    logic [PIECE_W-1:0]  blockstate_new;
    logic [SPRITE_W-1:0] spriteindex;
    logic [PIECE_W-1:0]  blockstate_hold;
    logic [SPRITE_W-1:0] spriteindex_hold;
    logic                hold_valid;
    logic                resetBlocks;
    logic                drop_tick;
    logic                Pause;
    logic                game_over;
    logic [LEVEL_W-1:0]  level;
    logic [LINES_W-1:0]  lines_total;
    logic [2:0]          dbg_state;

    modport master (
        input  keycode, hitbottom, topout, lines_cleared, pick_blockstate, pick_sprite,
        output pick_req, blockstate_new, spriteindex, blockstate_hold, spriteindex_hold,
               hold_valid, resetBlocks, drop_tick, Pause, game_over, level, lines_total,
               dbg_state
    );

    modport slave (
        output keycode, hitbottom, topout, lines_cleared, pick_blockstate, pick_sprite,
        input  pick_req, blockstate_new, spriteindex, blockstate_hold, spriteindex_hold,
               hold_valid, resetBlocks, drop_tick, Pause, game_over, level, lines_total,
               dbg_state
    );
endinterface

// File: rtl/tetris_game_ctrl.sv
// Tetris game-flow controller: start/drop/fall/hold/bottom/pause/over sequencing with
// key edge detection, a hold slot, level-scaled gravity and line/level accounting.
module tetris_game_ctrl #(
    parameter int               PIECE_W         = 16,
    parameter int               SPRITE_W        = 6,
    parameter logic [7:0]       KEY_START       = 8'h2C,
    parameter logic [7:0]       KEY_PAUSE       = 8'h13,
    parameter logic [7:0]       KEY_HOLD        = 8'h2B,
    parameter logic [7:0]       KEY_QUIT        = 8'h29,
    parameter int               GRAV_W          = 24,
    parameter logic [GRAV_W-1:0] GRAV_INIT      = 24'd5_000_000,
    parameter logic [GRAV_W-1:0] GRAV_STEP      = 24'd400_000,
    parameter logic [GRAV_W-1:0] GRAV_MIN       = 24'd500_000,
    parameter int               LINES_PER_LEVEL = 10,
    parameter int               LEVEL_W         = 4,
    parameter int               LINES_W         = 12
) (
    input logic                Clk,
    input logic                Reset_n,
    tetris_game_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_WAIT, S_DROP, S_FALLING, S_HOLD, S_BOTTOM, S_PAUSED, S_OVER
    } state_t;

    localparam int PW  = GRAV_W + LEVEL_W;
    localparam int LSW = LINES_W + 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    state_t              state_q;
    logic [7:0]          key_q;
    logic [PIECE_W-1:0]  active_q, hold_q;
    logic [SPRITE_W-1:0] sprite_q, hold_sprite_q;
    logic                hold_valid_q, can_hold_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [LINES_W-1:0]  lines_q;
    logic [2:0]          lc_q;
    logic [GRAV_W-1:0]   grav_q;

    logic press_start, press_pause, press_hold, press_quit;
    logic drop_tick;

    assign press_start = (bus.keycode == KEY_START) && (key_q != KEY_START);
    assign press_pause = (bus.keycode == KEY_PAUSE) && (key_q != KEY_PAUSE);
    assign press_hold  = (bus.keycode == KEY_HOLD)  && (key_q != KEY_HOLD);
    assign press_quit  = (bus.keycode == KEY_QUIT)  && (key_q != KEY_QUIT);

    // Gravity period shrinks with level; the wide product catches underflow.
    logic [PW-1:0]     grav_prod, grav_diff;
    logic [GRAV_W-1:0] period;

    always_comb begin
        grav_prod = PW'(level_q) * PW'(GRAV_STEP);
        grav_diff = PW'(GRAV_INIT) - grav_prod;
        if ((grav_prod > PW'(GRAV_INIT)) || (grav_diff < PW'(GRAV_MIN))) begin
            period = GRAV_MIN;
        end else begin
            period = grav_diff[GRAV_W-1:0];
        end
    end

    assign drop_tick = (state_q == S_FALLING) && (grav_q == period - GRAV_W'(1));

    // Line accounting: saturating total, one level per LINES_PER_LEVEL boundary crossed.
    logic [LSW-1:0]     lines_sum, lvl_sum;
    logic [LINES_W-1:0] lines_d, crossings;
    logic [LEVEL_W-1:0] level_d;

    always_comb begin
        lines_sum = {1'b0, lines_q} + LSW'(lc_q);
        lines_d   = lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
        crossings = (lines_d / LINES_W'(LINES_PER_LEVEL)) - (lines_q / LINES_W'(LINES_PER_LEVEL));
        lvl_sum   = LSW'(level_q) + LSW'(crossings);
        if (lvl_sum > LSW'(LEVEL_MAX)) begin
            level_d = LEVEL_MAX;
        end else begin
            level_d = lvl_sum[LEVEL_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_WAIT;
            key_q         <= 8'h00;
            active_q      <= '0;
            sprite_q      <= '0;
            hold_q        <= '0;
            hold_sprite_q <= '0;
            hold_valid_q  <= 1'b0;
            can_hold_q    <= 1'b1;
            level_q       <= '0;
            lines_q       <= '0;
            lc_q          <= '0;
            grav_q        <= '0;
        end else begin
            key_q <= bus.keycode;
            case (state_q)
                S_WAIT: begin
                    if (press_start) begin
                        level_q       <= '0;
                        lines_q       <= '0;
                        hold_q        <= '0;
                        hold_sprite_q <= '0;
                        hold_valid_q  <= 1'b0;
                        can_hold_q    <= 1'b1;
                        state_q       <= S_DROP;
                    end
                end
                S_DROP: begin
                    active_q <= bus.pick_blockstate;
                    sprite_q <= bus.pick_sprite;
                    grav_q   <= '0;
                    state_q  <= bus.topout ? S_OVER : S_FALLING;
                end
                S_FALLING: begin
                    grav_q <= drop_tick ? '0 : grav_q + GRAV_W'(1);
                    if (press_quit) begin
                        state_q <= S_WAIT;
                    end else if (bus.hitbottom) begin
                        // lines_cleared is only valid alongside hitbottom, so keep a copy.
                        lc_q    <= bus.lines_cleared;
                        state_q <= S_BOTTOM;
                    end else if (press_hold && can_hold_q) begin
                        state_q <= S_HOLD;
                    end else if (press_pause) begin
                        state_q <= S_PAUSED;
                    end
                end
                S_HOLD: begin
                    can_hold_q <= 1'b0;
                    grav_q     <= '0;
                    hold_q        <= active_q;
                    hold_sprite_q <= sprite_q;
                    if (!hold_valid_q) begin
                        active_q     <= bus.pick_blockstate;
                        sprite_q     <= bus.pick_sprite;
                        hold_valid_q <= 1'b1;
                    end else begin
                        active_q <= hold_q;
                        sprite_q <= hold_sprite_q;
                    end
                    state_q <= S_FALLING;
                end
                S_BOTTOM: begin
                    lines_q    <= lines_d;
                    level_q    <= level_d;
                    can_hold_q <= 1'b1;
                    state_q    <= S_DROP;
                end
                S_PAUSED: begin
                    if (press_quit) begin
                        state_q <= S_WAIT;
                    end else if (press_pause) begin
                        state_q <= S_FALLING;
                    end
                end
                S_OVER: begin
                    if (press_start) begin
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign bus.pick_req         = (state_q == S_WAIT) || (state_q == S_DROP) ||
                                  ((state_q == S_HOLD) && !hold_valid_q);
    assign bus.resetBlocks      = (state_q == S_DROP) || (state_q == S_HOLD);
    assign bus.drop_tick        = drop_tick;
    assign bus.Pause            = (state_q == S_WAIT) || (state_q == S_PAUSED) ||
                                  (state_q == S_OVER);
    assign bus.game_over        = (state_q == S_OVER);
    assign bus.blockstate_new   = active_q;
    assign bus.spriteindex      = sprite_q;
    assign bus.blockstate_hold  = hold_q;
    assign bus.spriteindex_hold = hold_sprite_q;
    assign bus.hold_valid       = hold_valid_q;
    assign bus.level            = level_q;
    assign bus.lines_total      = lines_q;
    assign bus.dbg_state        = state_q;
endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl: a game-rules model checked every cycle plus
// hand-computed expectations at the interesting points of a scripted game.
module tb_tetris_game_ctrl;
    localparam int GI = 8, GS = 2, GM = 2, LPL = 4;
    localparam int LINES_MAX = 4095, LEVEL_MAX = 15;
    localparam logic [7:0] KS = 8'h2C, KP = 8'h13, KH = 8'h2B, KQ = 8'h29;
    localparam int PH_WAIT = 0, PH_DROP = 1, PH_FALL = 2, PH_HOLD = 3,
                   PH_BOT = 4, PH_PAUSE = 5, PH_OVER = 6;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    tetris_game_ctrl_if #(.PIECE_W(16), .SPRITE_W(6), .LEVEL_W(4), .LINES_W(12)) bus ();

    tetris_game_ctrl #(
        .GRAV_INIT(24'd8), .GRAV_STEP(24'd2), .GRAV_MIN(24'd2), .LINES_PER_LEVEL(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- game-rules model ----------------
    int         m_ph, m_level, m_lines, m_fall, m_lc;
    logic [7:0] m_key;
    logic [15:0] m_act, m_hold;
    logic [5:0]  m_spr, m_hspr;
    bit          m_hv, m_can;

    function automatic int m_period(input int lvl);
        int p;
        p = GI - lvl * GS;
        if (p < GM) p = GM;
        return p;
    endfunction

    task automatic model_reset();
        m_ph = PH_WAIT; m_key = 8'h00; m_level = 0; m_lines = 0; m_fall = 0; m_lc = 0;
        m_act = '0; m_hold = '0; m_spr = '0; m_hspr = '0; m_hv = 1'b0; m_can = 1'b1;
    endtask

    task automatic model_step();
        logic [7:0] k;
        logic [15:0] tb;
        logic [5:0] ts;
        bit ps, pp, ph, pq;
        k  = bus.keycode;
        ps = (k == KS) && (m_key != KS);
        pp = (k == KP) && (m_key != KP);
        ph = (k == KH) && (m_key != KH);
        pq = (k == KQ) && (m_key != KQ);
        m_key = k;
        case (m_ph)
            PH_WAIT: if (ps) begin
                m_level = 0; m_lines = 0; m_hold = '0; m_hspr = '0; m_hv = 1'b0; m_can = 1'b1;
                m_ph = PH_DROP;
            end
            PH_DROP: begin
                m_act = bus.pick_blockstate; m_spr = bus.pick_sprite; m_fall = 0;
                m_ph = bus.topout ? PH_OVER : PH_FALL;
            end
            PH_FALL: begin
                m_fall++;
                if (pq) m_ph = PH_WAIT;
                else if (bus.hitbottom) begin m_lc = int'(bus.lines_cleared); m_ph = PH_BOT; end
                else if (ph && m_can) m_ph = PH_HOLD;
                else if (pp) m_ph = PH_PAUSE;
            end
            PH_HOLD: begin
                m_can = 1'b0; m_fall = 0;
                if (!m_hv) begin
                    m_hold = m_act; m_hspr = m_spr;
                    m_act = bus.pick_blockstate; m_spr = bus.pick_sprite; m_hv = 1'b1;
                end else begin
                    tb = m_act; ts = m_spr;
                    m_act = m_hold; m_spr = m_hspr; m_hold = tb; m_hspr = ts;
                end
                m_ph = PH_FALL;
            end
            PH_BOT: begin
                // add lines one at a time, counting each multiple of LPL reached
                for (int i = 0; i < m_lc; i++) begin
                    if (m_lines < LINES_MAX) begin
                        m_lines++;
                        if ((m_lines % LPL) == 0 && m_level < LEVEL_MAX) m_level++;
                    end
                end
                m_can = 1'b1; m_ph = PH_DROP;
            end
            PH_PAUSE: if (pq) m_ph = PH_WAIT; else if (pp) m_ph = PH_FALL;
            PH_OVER:  if (ps) m_ph = PH_WAIT;
            default:  m_ph = PH_WAIT;
        endcase
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (chk_en) begin
            check("pick_req", bus.pick_req,
                  (m_ph == PH_WAIT) || (m_ph == PH_DROP) || (m_ph == PH_HOLD && !m_hv));
            check("resetBlocks", bus.resetBlocks, (m_ph == PH_DROP) || (m_ph == PH_HOLD));
            check("drop_tick", bus.drop_tick,
                  (m_ph == PH_FALL) && (((m_fall + 1) % m_period(m_level)) == 0));
            check("Pause", bus.Pause, (m_ph == PH_WAIT) || (m_ph == PH_PAUSE) || (m_ph == PH_OVER));
            check("game_over", bus.game_over, m_ph == PH_OVER);
            check("hold_valid", bus.hold_valid, m_hv);
            check("level", bus.level, m_level);
            check("lines_total", bus.lines_total, m_lines);
            check("blockstate_new", bus.blockstate_new, m_act);
            check("spriteindex", bus.spriteindex, m_spr);
            check("blockstate_hold", bus.blockstate_hold, m_hold);
            check("spriteindex_hold", bus.spriteindex_hold, m_hspr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // From a FALLING negedge: land a piece, end on the first FALLING negedge after DROP.
    task automatic do_bottom(input logic [2:0] lc);
        bus.hitbottom = 1'b1; bus.lines_cleared = lc;
        cyc(1);
        bus.hitbottom = 1'b0; bus.lines_cleared = 3'd0;
        cyc(2);
    endtask

    // From the first FALLING negedge after DROP/HOLD: count cycles up to the first tick.
    task automatic measure_period(input string name, input int exp);
        int n;
        n = 1;
        while (!bus.drop_tick && n < 40) begin
            cyc(1);
            n++;
        end
        check(name, n, exp);
    endtask

    task automatic drain_ticks(input string name);
        while (obs_q.size() > 0) begin
            if (exp_q.size() == 0) check(name, obs_q.pop_front(), 8'hFF);
            else check(name, obs_q.pop_front(), exp_q.pop_front());
        end
        check({name, "_missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- directed script ----------------
    initial begin
        int rb_cnt;
        logic [2:0] dbg_wait;
        bus.keycode = 8'h00; bus.hitbottom = 1'b0; bus.topout = 1'b0; bus.lines_cleared = 3'd0;
        bus.pick_blockstate = 16'h4460; bus.pick_sprite = 6'd1;

        cyc(2);
        check("rst_Pause", bus.Pause, 1);
        check("rst_pick_req", bus.pick_req, 1);
        check("rst_hold_valid", bus.hold_valid, 0);
        check("rst_level", bus.level, 0);
        check("rst_drop_tick", bus.drop_tick, 0);
        check("rst_game_over", bus.game_over, 0);
        dbg_wait = bus.dbg_state;
        Reset_n = 1'b1;
        chk_en = 1'b1;

        // start key held for 20 cycles: one DROP, then FALLING with ticks at 8/16/24
        bus.keycode = KS;
        rb_cnt = 0;
        exp_q.push_back(8'd8); exp_q.push_back(8'd16); exp_q.push_back(8'd24);
        for (int s = 1; s <= 25; s++) begin
            cyc(1);
            if (s == 1) begin
                check("drop_pick_req", bus.pick_req, 1);
                check("dbg_state_moves", bus.dbg_state != dbg_wait, 1);
            end
            if (s == 2) check("drop_load", bus.blockstate_new, 16'h4460);
            if (bus.resetBlocks) rb_cnt++;
            if (bus.drop_tick) obs_q.push_back(8'(s - 1));
            if (s == 20) bus.keycode = 8'h00;
        end
        check("start_once", rb_cnt, 1);
        drain_ticks("tick_lvl0");

        // pause on the 12th cycle, 30 paused cycles, resume: tick after 4 more
        exp_q.push_back(8'd8);
        for (int r = 1; r <= 12; r++) begin
            cyc(1);
            if (bus.drop_tick) obs_q.push_back(8'(r));
            if (r == 12) bus.keycode = KP;
        end
        drain_ticks("tick_prepause");
        rb_cnt = 0;
        for (int p = 1; p <= 30; p++) begin
            cyc(1);
            if (p == 1) bus.keycode = 8'h00;
            if (bus.drop_tick) rb_cnt++;
            if (p == 30) bus.keycode = KP;
        end
        check("paused_ticks", rb_cnt, 0);
        exp_q.push_back(8'd4);
        for (int q = 1; q <= 4; q++) begin
            cyc(1);
            if (q == 1) bus.keycode = 8'h00;
            if (bus.drop_tick) obs_q.push_back(8'(q));
        end
        drain_ticks("tick_resume");

        // first hold takes the picker, second hold before bottom is ignored
        bus.pick_blockstate = 16'h0F00; bus.pick_sprite = 6'd3;
        bus.keycode = KH;
        cyc(1);
        check("hold1_pick_req", bus.pick_req, 1);
        check("hold1_resetBlocks", bus.resetBlocks, 1);
        bus.keycode = 8'h00;
        cyc(1);
        check("hold1_slot", bus.blockstate_hold, 16'h4460);
        check("hold1_active", bus.blockstate_new, 16'h0F00);
        check("hold1_sprite", bus.spriteindex, 3);
        check("hold1_valid", bus.hold_valid, 1);
        bus.keycode = KH;
        cyc(1);
        check("hold2_ignored", bus.resetBlocks, 0);
        check("hold2_active", bus.blockstate_new, 16'h0F00);
        bus.keycode = 8'h00;

        // land with 3 lines, then hold swaps without asking the picker
        bus.pick_blockstate = 16'h0660; bus.pick_sprite = 6'd5;
        do_bottom(3'd3);
        check("lines_3", bus.lines_total, 3);
        check("level_0", bus.level, 0);
        bus.keycode = KH;
        cyc(1);
        check("swap_pick_req", bus.pick_req, 0);
        check("swap_resetBlocks", bus.resetBlocks, 1);
        bus.keycode = 8'h00;
        cyc(1);
        check("swap_active", bus.blockstate_new, 16'h4460);
        check("swap_sprite", bus.spriteindex, 1);
        check("swap_hold", bus.blockstate_hold, 16'h0660);
        check("swap_hold_sprite", bus.spriteindex_hold, 5);

        // hitbottom together with a hold press: bottom wins, hold slot untouched
        bus.pick_blockstate = 16'h0E40; bus.pick_sprite = 6'd2;
        do_bottom(3'd0);
        bus.hitbottom = 1'b1; bus.lines_cleared = 3'd3; bus.keycode = KH;
        cyc(1);
        check("simul_no_hold", bus.resetBlocks, 0);
        bus.hitbottom = 1'b0; bus.lines_cleared = 3'd0; bus.keycode = 8'h00;
        cyc(2);
        check("lines_6", bus.lines_total, 6);
        check("level_1", bus.level, 1);
        check("simul_hold_kept", bus.blockstate_hold, 16'h0660);
        check("simul_active", bus.blockstate_new, 16'h0E40);
        measure_period("period_lvl1", 6);

        // climb to level 7: period clamps to the floor
        for (int i = 0; i < 5; i++) do_bottom(3'd4);
        do_bottom(3'd2);
        check("lines_28", bus.lines_total, 28);
        check("level_7", bus.level, 7);
        measure_period("period_lvl7", 2);

        // top-out on the next spawn
        bus.hitbottom = 1'b1; bus.lines_cleared = 3'd0;
        cyc(1);
        bus.hitbottom = 1'b0; bus.topout = 1'b1;
        cyc(1);
        check("topout_drop", bus.resetBlocks, 1);
        cyc(1);
        bus.topout = 1'b0;
        check("over_game_over", bus.game_over, 1);
        check("over_Pause", bus.Pause, 1);
        bus.keycode = KS;
        cyc(1);
        check("over_exit_game_over", bus.game_over, 0);
        check("wait_Pause", bus.Pause, 1);
        check("wait_lines_kept", bus.lines_total, 28);
        bus.keycode = 8'h00;
        cyc(1);
        bus.keycode = KS;
        cyc(1);
        bus.keycode = 8'h00;
        cyc(1);
        check("restart_level", bus.level, 0);
        check("restart_lines", bus.lines_total, 0);
        check("restart_Pause", bus.Pause, 0);

        // asynchronous reset mid-game
        do_bottom(3'd4);
        bus.keycode = KH;
        cyc(1);
        bus.keycode = 8'h00;
        cyc(1);
        check("pre_reset_hold_valid", bus.hold_valid, 1);
        check("pre_reset_level", bus.level, 1);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_hold_valid", bus.hold_valid, 0);
        check("async_level", bus.level, 0);
        check("async_Pause", bus.Pause, 1);
        check("async_pick_req", bus.pick_req, 1);
        check("async_drop_tick", bus.drop_tick, 0);
        check("async_resetBlocks", bus.resetBlocks, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
